mario_life_ctrl: RTL

- Consumes the combinational collision flag produced by the goomba collision stage.
- Turns a level collision flag into game consequences: life loss, death pause, respawn request, post-respawn invincibility with sprite blink, and game over.
- Sits between collision detection and the Mario movement and display logic; its outputs gate Mario's position reset and visibility.

---
 rtl/mario_life_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mario_life_ctrl.sv
// Mario life/death controller: converts a level collision flag into life loss,
// death pause, respawn, blinking post-respawn invincibility and game over.
module mario_life_ctrl #(
    parameter int unsigned LIVES_INIT       = 3,
    parameter int unsigned DEATH_TICKS      = 60,
    parameter int unsigned INVINCIBLE_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       mario_hit,
    output logic [2:0] lives,
    output logic       playing,
    output logic       dying,
    output logic       invincible,
    output logic       game_over,
    output logic       hit_pulse,
    output logic       respawn,
    output logic       mario_visible
);

    localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
    localparam logic [7:0] DEATH_T   = 8'(DEATH_TICKS);
    localparam logic [7:0] INVINC_T  = 8'(INVINCIBLE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_DYING,
        S_INVINC,
        S_OVER
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       playing_q, playing_d;
    logic       dying_q, dying_d;
    logic       invinc_q, invinc_d;
    logic       over_q, over_d;
    logic       hit_q, hit_d;
    logic       respawn_q, respawn_d;
    logic       visible_q, visible_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lives_q   <= LIVES_RST;
            timer_q   <= '0;
            playing_q <= 1'b0;
            dying_q   <= 1'b0;
            invinc_q  <= 1'b0;
            over_q    <= 1'b0;
            hit_q     <= 1'b0;
            respawn_q <= 1'b0;
            visible_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            timer_q   <= timer_d;
            playing_q <= playing_d;
            dying_q   <= dying_d;
            invinc_q  <= invinc_d;
            over_q    <= over_d;
            hit_q     <= hit_d;
            respawn_q <= respawn_d;
            visible_q <= visible_d;
        end
    end

    // A hit accepted in PLAY loads the timer directly, so a coincident tick is dropped.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (game_start) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_RST;
                end
            end
            S_PLAY: begin
                if (mario_hit) begin
                    state_d = S_DYING;
                    lives_d = lives_q - 3'd1;
                    timer_d = DEATH_T;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (timer_q == 8'd1) begin
                        if (lives_q == '0) begin
                            state_d = S_OVER;
                            timer_d = '0;
                        end else begin
                            state_d = S_INVINC;
                            timer_d = INVINC_T;
                        end
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            S_INVINC: begin
                if (frame_tick) begin
                    if (timer_q == 8'd1) begin
                        state_d = S_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every port comes straight from a flop.
    always_comb begin
        playing_d = (state_d == S_PLAY) || (state_d == S_INVINC);
        dying_d   = (state_d == S_DYING);
        invinc_d  = (state_d == S_INVINC);
        over_d    = (state_d == S_OVER);
        hit_d     = (state_q == S_PLAY) && (state_d == S_DYING);
        respawn_d = ((state_q == S_IDLE || state_q == S_OVER) && state_d == S_PLAY)
                 || ((state_q == S_DYING) && (state_d == S_INVINC));
        visible_d = (state_d == S_INVINC) ? ~timer_d[2] : 1'b1;
    end

    assign lives         = lives_q;
    assign playing       = playing_q;
    assign dying         = dying_q;
    assign invincible    = invinc_q;
    assign game_over     = over_q;
    assign hit_pulse     = hit_q;
    assign respawn       = respawn_q;
    assign mario_visible = visible_q;

endmodule
